// File: rtl/key_sched_ctrl.sv
// rtl/key_sched_ctrl.sv - AES-128 key schedule controller with 11-entry round-key store
//
// Purpose: expands a 128-bit cipher key into 11 round keys, one round per
// CYC_PER_RND clock cycles, using the single-round stage Key_Expansion.
// The round keys are held in a local store that can be read at any time.
//
// Optional feature: define KEY_SCHED_REV_READ_EN to read the store in
// decryption order (index i returns rk[10-i]); by default index i returns rk[i].
//
// Ports (key_sched_ctrl):
//   clk        in   1    single clock, rising edge
//   rst        in   1    synchronous active-high reset
//   start      in   1    expand key_in (accepted only in IDLE)
//   key_in     in   128  cipher key, w0 = key_in[127:96]
//   busy       out  1    expansion in progress
//   done       out  1    one-cycle pulse when all round keys are stored
//   rk_valid   out  1    store holds a complete schedule
//   rk_rd_idx  in   4    round-key read index 0..10
//   rk_rd_data out  128  registered read data (0 for index > 10)
//
// Ports (Key_Expansion): key 128 in, round_no 4 in, clk in, S 128 out
// (registered next round key; round_no 0 uses a zero round constant).

module Key_Expansion (
   input  logic [127:0] key,
   input  logic [3:0]   round_no,
   input  logic         clk,
   output logic [127:0] S
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] base;
      logic [7:0] e;
      r    = 8'h01;
      base = x;
      e    = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gmul(r, base);
         base = gmul(base, base);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
               ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   logic [7:0]  rcon;
   logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;

   always_comb begin
      case (round_no)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
      {w0, w1, w2, w3} = key;
      rot = {w3[23:0], w3[31:24]};
      t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
            ^ {rcon, 24'h000000};
      n0  = w0 ^ t;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
   end

   always_ff @(posedge clk) begin
      S <= {n0, n1, n2, n3};
   end
endmodule

module key_sched_ctrl #(
   parameter int CYC_PER_RND = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         rk_valid,
   input  logic [3:0]   rk_rd_idx,
   output logic [127:0] rk_rd_data
);
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   localparam logic [1:0] CNT_LAST = 2'(CYC_PER_RND - 1);

   state_t       state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] cur_q, cur_d;
   logic         rk_valid_q, rk_valid_d;
   logic [127:0] rd_data_q;
   logic [127:0] rk_q [0:10];

   logic         rk_we;
   logic [3:0]   rk_waddr;
   logic [127:0] rk_wdata;
   logic [3:0]   stage_round;
   logic [127:0] stage_s;
   logic [3:0]   rd_sel;

   // The stage registers its output, so S reflects (cur, rnd) one cycle after
   // they change; CYC_PER_RND >= 2 keeps the capture edge after that point.
   Key_Expansion u_stage (
      .key      (cur_q),
      .round_no (stage_round),
      .clk      (clk),
      .S        (stage_s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rnd_d       = rnd_q;
      cur_d       = cur_q;
      rk_valid_d  = rk_valid_q;
      rk_we       = 1'b0;
      rk_waddr    = 4'd0;
      rk_wdata    = 128'h0;
      stage_round = 4'd0;
      case (state_q)
         IDLE: begin
            if (start) begin
               rk_we      = 1'b1;
               rk_waddr   = 4'd0;
               rk_wdata   = key_in;
               cur_d      = key_in;
               rnd_d      = 4'd1;
               cnt_d      = 2'd0;
               rk_valid_d = 1'b0;
               state_d    = EXPAND;
            end
         end
         EXPAND: begin
            stage_round = rnd_q;
            if (cnt_q == CNT_LAST) begin
               rk_we    = 1'b1;
               rk_waddr = rnd_q;
               rk_wdata = stage_s;
               cur_d    = stage_s;
               cnt_d    = 2'd0;
               if (rnd_q == 4'd10) begin
                  state_d    = DONE;
                  rk_valid_d = 1'b1;
               end else begin
                  rnd_d = rnd_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         rnd_q      <= 4'd0;
         cur_q      <= 128'h0;
         rk_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rnd_q      <= rnd_d;
         cur_q      <= cur_d;
         rk_valid_q <= rk_valid_d;
      end
   end

   // Store contents are not reset; rk_valid gates their use.
   always_ff @(posedge clk) begin
      if (!rst && rk_we) rk_q[rk_waddr] <= rk_wdata;
   end

`ifdef KEY_SCHED_REV_READ_EN
   assign rd_sel = 4'd10 - rk_rd_idx;
`else
   assign rd_sel = rk_rd_idx;
`endif

   always_ff @(posedge clk) begin
      if (rst)                    rd_data_q <= 128'h0;
      else if (rk_rd_idx > 4'd10) rd_data_q <= 128'h0;
      else                        rd_data_q <= rk_q[rd_sel];
   end

   assign busy       = (state_q == EXPAND);
   assign done       = (state_q == DONE);
   assign rk_valid   = rk_valid_q;
   assign rk_rd_data = rd_data_q;
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb/tb_key_sched_ctrl.sv - directed self-checking bench for key_sched_ctrl
//
// Drives directed key-expansion scenarios on key_sched_ctrl and compares its
// outputs against hand-computed AES-128 round keys and cycle counts.
// Honours KEY_SCHED_REV_READ_EN for the read-index mapping.

module tb_key_sched_ctrl;
   localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R1_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] R2_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

`ifdef KEY_SCHED_REV_READ_EN
   localparam logic [3:0] IDX_RK0  = 4'd10;
   localparam logic [3:0] IDX_RK1  = 4'd9;
   localparam logic [3:0] IDX_RK10 = 4'd0;
`else
   localparam logic [3:0] IDX_RK0  = 4'd0;
   localparam logic [3:0] IDX_RK1  = 4'd1;
   localparam logic [3:0] IDX_RK10 = 4'd10;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         done;
   logic         rk_valid;
   logic [3:0]   rk_rd_idx;
   logic [127:0] rk_rd_data;

   int tests = 0;
   int fails = 0;
   int n;

   key_sched_ctrl #(.CYC_PER_RND(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key_in     (key_in),
      .busy       (busy),
      .done       (done),
      .rk_valid   (rk_valid),
      .rk_rd_idx  (rk_rd_idx),
      .rk_rd_data (rk_rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called right after the accept edge; counts cycles with busy high.
   task automatic count_busy(output int cnt);
      cnt = busy ? 1 : 0;
      for (int i = 0; i < 100 && busy; i++) begin
         tick();
         if (busy) cnt++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; key_in = 128'h0; rk_rd_idx = 4'd0;
      tick();
      tick();
      check("rst_busy",     128'(busy),     128'd0);
      check("rst_done",     128'(done),     128'd0);
      check("rst_rk_valid", 128'(rk_valid), 128'd0);
      check("rst_rd_data",  rk_rd_data,     128'h0);
      rst = 1'b0;
      tick();

      // First expansion, with a start pulse and key change at E5 to be ignored.
      key_in = K1; start = 1'b1;
      tick();                               // E0
      start = 1'b0;
      check("a_accept_busy",     128'(busy),     128'd1);
      check("a_accept_rk_valid", 128'(rk_valid), 128'd0);
      n = 1;
      repeat (4) begin tick(); if (busy) n++; end
      start = 1'b1; key_in = K2;
      tick();                               // E5
      start = 1'b0;
      if (busy) n++;
      for (int i = 0; i < 100 && busy; i++) begin
         tick();
         if (busy) n++;
      end
      check("a_busy_cycles", 128'(n),        128'd20);
      check("a_e20_done",    128'(done),     128'd1);
      check("a_e20_valid",   128'(rk_valid), 128'd1);
      check("a_e20_busy",    128'(busy),     128'd0);
      tick();                               // E21
      check("a_e21_done",    128'(done),     128'd0);
      check("a_e21_valid",   128'(rk_valid), 128'd1);

      rk_rd_idx = IDX_RK0;  tick(); check("a_rd_rk0",  rk_rd_data, K1);
      rk_rd_idx = IDX_RK1;  tick(); check("a_rd_rk1",  rk_rd_data, R1_1);
      rk_rd_idx = IDX_RK10; tick(); check("a_rd_rk10", rk_rd_data, R1_10);
      rk_rd_idx = 4'd11;
      check("rd_latency_hold", rk_rd_data, R1_10);
      for (int i = 11; i <= 15; i++) begin
         rk_rd_idx = 4'(i);
         tick();
         check($sformatf("rd_oob_%0d", i), rk_rd_data, 128'h0);
      end

      // Restart with a second key after done.
      key_in = K2; start = 1'b1;
      tick();
      start = 1'b0;
      check("b_accept_valid", 128'(rk_valid), 128'd0);
      check("b_accept_busy",  128'(busy),     128'd1);
      count_busy(n);
      check("b_busy_cycles", 128'(n),        128'd20);
      check("b_done",        128'(done),     128'd1);
      check("b_valid",       128'(rk_valid), 128'd1);
      rk_rd_idx = IDX_RK10; tick(); check("b_rd_rk10", rk_rd_data, R2_10);
      rk_rd_idx = IDX_RK0;  tick(); check("b_rd_rk0",  rk_rd_data, K2);

      // Reset at E8 abandons the schedule; a fresh start then completes.
      key_in = K1; start = 1'b1;
      tick();                               // E0
      start = 1'b0;
      repeat (7) tick();                    // E7
      check("c_pre_rst_busy", 128'(busy), 128'd1);
      rst = 1'b1;
      tick();                               // E8
      rst = 1'b0;
      check("c_rst_busy",    128'(busy),     128'd0);
      check("c_rst_valid",   128'(rk_valid), 128'd0);
      check("c_rst_done",    128'(done),     128'd0);
      check("c_rst_rd_data", rk_rd_data,     128'h0);
      tick();
      check("c_idle_busy",   128'(busy),     128'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      count_busy(n);
      check("c_busy_cycles", 128'(n),        128'd20);
      check("c_done",        128'(done),     128'd1);
      check("c_valid",       128'(rk_valid), 128'd1);
      rk_rd_idx = IDX_RK10; tick(); check("c_rd_rk10", rk_rd_data, R1_10);
      rk_rd_idx = IDX_RK1;  tick(); check("c_rd_rk1",  rk_rd_data, R1_1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
